// File: rtl/ptp_rtc_timer_if.sv
// ptp_rtc_timer_if: register bus between the host and the PTP real-time clock.
interface ptp_rtc_timer_if;
   logic [7:0]  addr;
   logic        wr;
   logic        rd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master (output addr, wr, rd, wdata, input rdata);
   modport slave (input addr, wr, rd, wdata, output rdata);
endinterface

// File: rtl/ptp_rtc_timer.sv
// ptp_rtc_timer: IEEE 1588 RTC with 48-bit sec / 30-bit ns / 26-bit frac counter, PPS out and PPS capture.
// Define RTC_PPS_CAPTURE_EN to build the pps_i synchronizer, pts_std/pts_vld and registers 0x14-0x1C.
module ptp_rtc_timer (
   input  logic                  clk,
   input  logic                  rst_n,
   ptp_rtc_timer_if.slave        bus,
   input  logic                  pps_i,
   output logic [79:0]           rtc_std,
   output logic                  pps_o,
   output logic [79:0]           pts_std,
   output logic                  pts_vld
);
   localparam logic [30:0] NS_SEC = 31'd1_000_000_000;
   localparam logic [29:0] NS_MAX = 30'd999_999_999;
   logic [1:0]  ctl_q, ctl_d;
   logic [15:0] sc0_q, sc0_d;
   logic [31:0] sc1_q, sc1_d, nso_q, nso_d, tick_q, tick_d, rdata_q, rdata_d, rd_val;
   logic [47:0] sec_q, sec_d;
   logic [29:0] ns_q, ns_d, ns_inc;
   logic [25:0] frac_q, frac_d;
   logic        pps_q, pps_d, roll;
   logic [56:0] sum;
   logic [30:0] ns_sum;
   logic [79:0] pts_q;
   assign rtc_std   = {sec_q, 2'b0, ns_q};
   assign pps_o     = pps_q;
   assign bus.rdata = rdata_q;
   always_comb begin
      ctl_d  = (bus.wr && bus.addr == 8'h00) ? bus.wdata[1:0] : 2'b0;
      sc0_d  = (bus.wr && bus.addr == 8'h04) ? bus.wdata[15:0] : sc0_q;
      sc1_d  = (bus.wr && bus.addr == 8'h08) ? bus.wdata : sc1_q;
      nso_d  = (bus.wr && bus.addr == 8'h0C) ? bus.wdata : nso_q;
      tick_d = (bus.wr && bus.addr == 8'h10) ? bus.wdata : tick_q;
      sum    = {1'b0, ns_q, frac_q} + {25'b0, tick_q};
      ns_sum = sum[56:26];
      roll   = ns_sum >= NS_SEC;
      ns_inc = roll ? 30'(ns_sum - NS_SEC) : ns_sum[29:0];
      sec_d  = ctl_q[1] ? 48'd0 : ctl_q[0] ? {sc0_q, sc1_q} : sec_q + 48'(roll);
      ns_d   = ctl_q[1] ? 30'd0 : ctl_q[0] ? (nso_q >= 32'(NS_SEC) ? NS_MAX : nso_q[29:0]) : ns_inc;
      frac_d = (ctl_q != 2'b0) ? 26'd0 : sum[25:0];
      pps_d  = ns_q < 30'd10_000_000;
      case (bus.addr)
         8'h04:   rd_val = {16'b0, sc0_q};
         8'h08:   rd_val = sc1_q;
         8'h0C:   rd_val = nso_q;
         8'h10:   rd_val = tick_q;
`ifdef RTC_PPS_CAPTURE_EN
         8'h14:   rd_val = {16'b0, pts_q[79:64]};
         8'h18:   rd_val = pts_q[63:32];
         8'h1C:   rd_val = pts_q[31:0];
`endif
         8'h20:   rd_val = {16'b0, sec_q[47:32]};
         8'h24:   rd_val = sec_q[31:0];
         8'h28:   rd_val = {2'b0, ns_q};
         default: rd_val = 32'd0;
      endcase
      rdata_d = bus.rd ? rd_val : rdata_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q   <= '0;
         sc0_q   <= '0;
         sc1_q   <= '0;
         nso_q   <= '0;
         tick_q  <= 32'h1999_999A;
         sec_q   <= '0;
         ns_q    <= '0;
         frac_q  <= '0;
         pps_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ctl_q   <= ctl_d;
         sc0_q   <= sc0_d;
         sc1_q   <= sc1_d;
         nso_q   <= nso_d;
         tick_q  <= tick_d;
         sec_q   <= sec_d;
         ns_q    <= ns_d;
         frac_q  <= frac_d;
         pps_q   <= pps_d;
         rdata_q <= rdata_d;
      end
   end
`ifdef RTC_PPS_CAPTURE_EN
   // sync_q: [0] first sync flop, [1] second sync flop, [2] previous value for edge detect
   logic [2:0]  sync_q, sync_d;
   logic [79:0] pts_d;
   logic        vld_q, vld_d;
   always_comb begin
      sync_d = {sync_q[1:0], pps_i};
      vld_d  = sync_q[1] & ~sync_q[2];
      pts_d  = vld_d ? rtc_std : pts_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         pts_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         pts_q  <= pts_d;
         vld_q  <= vld_d;
      end
   end
   assign pts_std = pts_q;
   assign pts_vld = vld_q;
`else
   logic unused_pps;
   assign unused_pps = pps_i;
   assign pts_q      = '0;
   assign pts_std    = '0;
   assign pts_vld    = 1'b0;
`endif
endmodule

// File: tb/tb_ptp_rtc_timer.sv
// tb_ptp_rtc_timer: directed self-checking bench for ptp_rtc_timer with a read-data scoreboard.
module tb_ptp_rtc_timer;
   localparam logic [31:0] T0 = 32'h1999_999A;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pps_i = 1'b0;
   logic [79:0] rtc_std, pts_std;
   logic        pps_o, pts_vld;
   logic [31:0] exp_q[$];
   int          n_assert = 0;
   int          n_fail = 0;
   ptp_rtc_timer_if bus ();
   ptp_rtc_timer dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .pps_i(pps_i),
      .rtc_std(rtc_std), .pps_o(pps_o), .pts_std(pts_std), .pts_vld(pts_vld)
   );
   always #5 clk = ~clk;
   function automatic logic [79:0] mdl(input logic [47:0] s, input logic [29:0] n, input int k, input logic [31:0] t);
      logic [63:0] q;
      q = ({34'b0, n, 26'b0} + 64'(k) * {32'b0, t}) >> 26;
      while (q >= 64'd1_000_000_000) begin
         q = q - 64'd1_000_000_000;
         s = s + 48'd1;
      end
      return {s, 2'b0, q[29:0]};
   endfunction
   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wr32(input logic [7:0] a, input logic [31:0] d);
      bus.addr = a; bus.wdata = d; bus.wr = 1'b1;
      tick;
      bus.wr = 1'b0;
   endtask
   task automatic rd32(input logic [7:0] a, input logic [31:0] e, input string tag);
      exp_q.push_back(e);
      bus.addr = a; bus.rd = 1'b1;
      tick;
      bus.rd = 1'b0;
      chk(tag, {48'b0, bus.rdata}, {48'b0, exp_q.pop_front()});
   endtask
   task automatic load(input logic [47:0] s, input logic [31:0] n);
      wr32(8'h04, {16'b0, s[47:32]});
      wr32(8'h08, s[31:0]);
      wr32(8'h0C, n);
      wr32(8'h00, 32'd1);
      tick;
   endtask
   initial begin
      logic [79:0] pts_exp;
      bus.addr = '0; bus.wr = 1'b0; bus.rd = 1'b0; bus.wdata = '0;
      repeat (3) tick;
      chk("rst_rtc", rtc_std, 80'd0);
      chk("rst_pps", {79'b0, pps_o}, 80'd0);
      chk("rst_pts", pts_std, 80'd0);
      chk("rst_vld", {79'b0, pts_vld}, 80'd0);
      chk("rst_rdata", {48'b0, bus.rdata}, 80'd0);
      rst_n = 1'b1;
      rd32(8'h10, T0, "rst_tick_inc");
      rd32(8'h08, 32'd0, "rst_shadow");
      load(48'h0000_1234_5678, 32'h0150_0000);
      chk("load_val", rtc_std, 80'h0000_1234_5678_0150_0000);
      for (int k = 1; k <= 20; k++) begin
         tick;
         chk("load_count", rtc_std, mdl(48'h0000_1234_5678, 30'h0150_0000, k, T0));
      end
      rd32(8'h24, 32'h1234_5678, "rd_rtc_sec_lo");
      rd32(8'h20, 32'd0, "rd_rtc_sec_hi");
      rd32(8'h0C, 32'h0150_0000, "rd_ns_ofst");
      rd32(8'h00, 32'd0, "rd_ctl_selfclr");
      rd32(8'h30, 32'd0, "rd_unmapped");
      wr32(8'h00, 32'd2);
      tick;
      chk("clear_val", rtc_std, 80'd0);
      for (int k = 1; k <= 5; k++) begin
         tick;
         chk("clear_count", rtc_std, mdl(48'd0, 30'd0, k, T0));
      end
      wr32(8'h00, 32'd3);
      tick;
      chk("clear_over_load", rtc_std, 80'd0);
      load(48'h0000_2222_3333, 32'd999_999_990);
      chk("roll_load", rtc_std, {48'h0000_2222_3333, 2'b0, 30'd999_999_990});
      tick;
      chk("roll_pre", rtc_std, {48'h0000_2222_3333, 2'b0, 30'd999_999_996});
      chk("roll_pps_lo0", {79'b0, pps_o}, 80'd0);
      tick;
      chk("roll_post", rtc_std, {48'h0000_2222_3334, 2'b0, 30'd2});
      chk("roll_pps_lo1", {79'b0, pps_o}, 80'd0);
      tick;
      chk("roll_pps_hi", {79'b0, pps_o}, 80'd1);
      load(48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF);
      chk("ns_clamp", rtc_std, {48'hFFFF_FFFF_FFFF, 2'b0, 30'd999_999_999});
      tick;
      chk("sec_wrap", rtc_std, {48'd0, 2'b0, 30'd5});
      wr32(8'h10, 32'h0400_0000);
      rd32(8'h10, 32'h0400_0000, "rd_tick_inc");
      load(48'd7, 32'd500);
      for (int k = 0; k <= 3; k++) begin
         chk("tick_1ns", rtc_std, mdl(48'd7, 30'd500, k, 32'h0400_0000));
         tick;
      end
      wr32(8'h10, T0);
      load(48'd5, 32'd100);
      pps_i = 1'b1;
      pts_exp = mdl(48'd5, 30'd100, 2, T0);
      tick;
      tick;
      chk("pts_vld_early", {79'b0, pts_vld}, 80'd0);
      tick;
`ifdef RTC_PPS_CAPTURE_EN
      chk("pts_vld", {79'b0, pts_vld}, 80'd1);
      chk("pts_std", pts_std, pts_exp);
      tick;
      chk("pts_vld_once", {79'b0, pts_vld}, 80'd0);
      rd32(8'h14, 32'd0, "rd_pts_sec_hi");
      rd32(8'h18, 32'd5, "rd_pts_sec_lo");
      rd32(8'h1C, pts_exp[31:0], "rd_pts_ns");
`else
      chk("pts_vld_off", {79'b0, pts_vld}, 80'd0);
      chk("pts_std_off", pts_std, 80'd0);
      rd32(8'h18, 32'd0, "rd_pts_sec_lo_off");
      rd32(8'h1C, 32'd0, "rd_pts_ns_off");
`endif
      rd32(8'h24, 32'd5, "rd_rtc_sec_pre_rst");
      pps_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rtc", rtc_std, 80'd0);
      chk("midrst_pps", {79'b0, pps_o}, 80'd0);
      chk("midrst_rdata", {48'b0, bus.rdata}, 80'd0);
      chk("midrst_pts", pts_std, 80'd0);
      #2 rst_n = 1'b1;
      tick;
      rd32(8'h10, T0, "midrst_tick_inc");
      rd32(8'h0C, 32'd0, "midrst_shadow");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
